// File: rtl/rv32i_types.sv
// ============================================================================
// Module      : rv32i_types
// Description : Shared types and constants for the memory-side cache blocks.
// Revision    : 1.0 - initial release with the cache arbiter state type
// ============================================================================
`default_nettype none

package rv32i_types;

    localparam int c_ADDR_W = 32;
    localparam int c_LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/cache_arbiter.sv
// ============================================================================
// Module      : cache_arbiter
// Description : Shares one memory line port between icache and dcache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_arbiter
    import rv32i_types::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int LINE_W = c_LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic              proto_err
);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic              r_last_d;
    logic              r_cmd_write;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [LINE_W-1:0] r_cmd_wdata;
    logic              r_proto_err;
    logic              w_i_req;
    logic              w_d_req;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_serve_i;
    logic              w_serve_d;

    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;

    // Ties go to whichever cache was not served last, so neither can starve.
    always_comb begin
        w_state_next = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_i_req && w_d_req) begin
                    w_grant_i = r_last_d;
                    w_grant_d = ~r_last_d;
                end else begin
                    w_grant_i = w_i_req;
                    w_grant_d = w_d_req;
                end
                if (w_grant_d) begin
                    w_state_next = SERVE_D;
                end else if (w_grant_i) begin
                    w_state_next = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A combined read+write from the dcache is carried out as a write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_d    <= 1'b0;
            r_cmd_write <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
        end else if (w_grant_d) begin
            r_last_d    <= 1'b1;
            r_cmd_write <= d_write;
            r_cmd_addr  <= d_addr;
            r_cmd_wdata <= d_wdata;
        end else if (w_grant_i) begin
            r_last_d    <= 1'b0;
            r_cmd_write <= 1'b0;
            r_cmd_addr  <= i_addr;
            r_cmd_wdata <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_proto_err <= 1'b0;
        end else if (d_read && d_write) begin
            r_proto_err <= 1'b1;
        end
    end

    assign w_serve_i = (r_state == SERVE_I);
    assign w_serve_d = (r_state == SERVE_D);

    assign mem_read  = (w_serve_i | w_serve_d) & ~r_cmd_write;
    assign mem_write = (w_serve_i | w_serve_d) & r_cmd_write;
    assign mem_addr  = r_cmd_addr;
    assign mem_wdata = r_cmd_wdata;

    assign i_resp    = w_serve_i & mem_resp;
    assign d_resp    = w_serve_d & mem_resp;
    assign i_rdata   = w_serve_i ? mem_rdata : '0;
    assign d_rdata   = w_serve_d ? mem_rdata : '0;
    assign proto_err = r_proto_err;

endmodule

`default_nettype wire

// File: tb/tb_cache_arbiter.sv
// ============================================================================
// Module      : tb_cache_arbiter
// Description : Directed self-checking bench for cache_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              clk;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;
    logic              proto_err;

    int n_checks;
    int n_fail;

    cache_arbiter #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_read    (i_read),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_resp    (i_resp),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_resp    (d_resp),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_resp  (mem_resp),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 2 time units after the rising edge, outputs are read 1 later.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        i_read    = 1'b0;
        i_addr    = '0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_resp  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        i_read    = 1'b1;
        i_addr    = 32'h0000_0100;
        d_read    = 1'b1;
        d_write   = 1'b0;
        d_addr    = 32'h0000_0200;
        d_wdata   = {8{32'hFFFF_FFFF}};
        mem_rdata = {8{32'h5A5A_5A5A}};
        mem_resp  = 1'b1;
        step();
        step();
        #1;
        n_checks++;
        if ({mem_read, mem_write, i_resp, d_resp, proto_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000", {mem_read, mem_write, i_resp, d_resp, proto_err});
        end
        n_checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_cmd: got addr %h wdata %h expected 0", mem_addr, mem_wdata);
        end
        n_checks++;
        if ((i_rdata | d_rdata) !== '0) begin
            n_fail++;
            $display("FAIL reset_rdata: got i %h d %h expected 0", i_rdata, d_rdata);
        end
        mem_resp = 1'b0;
        rst      = 1'b1;
        step();
        #1;
        n_checks++;
        if (mem_read !== 1'b1 || mem_addr !== 32'h0000_0200) begin
            n_fail++;
            $display("FAIL reset_tiebreak: got mem_read %b addr %h expected 1 00000200", mem_read, mem_addr);
        end
        do_reset();
    endtask

    task automatic test_icache_read();
        i_read = 1'b1;
        i_addr = 32'h0000_1000;
        #1;
        n_checks++;
        if (mem_read !== 1'b0) begin
            n_fail++;
            $display("FAIL icache_no_early_cmd: got %b expected 0", mem_read);
        end
        for (int k = 1; k <= 5; k++) begin
            step();
            mem_resp  = (k == 5);
            mem_rdata = (k == 5) ? {8{32'hA5A5_A5A5}} : '0;
            #1;
            n_checks++;
            if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h0000_1000) begin
                n_fail++;
                $display("FAIL icache_cmd_c%0d: got rd %b wr %b addr %h expected 1 0 00001000", k, mem_read, mem_write, mem_addr);
            end
            n_checks++;
            if (i_resp !== (k == 5) || d_resp !== 1'b0) begin
                n_fail++;
                $display("FAIL icache_resp_c%0d: got i %b d %b expected %b 0", k, i_resp, d_resp, (k == 5));
            end
        end
        n_checks++;
        if (i_rdata !== {8{32'hA5A5_A5A5}} || d_rdata !== '0) begin
            n_fail++;
            $display("FAIL icache_rdata: got i %h d %h", i_rdata, d_rdata);
        end
        step();
        i_read   = 1'b0;
        mem_resp = 1'b0;
        #1;
        n_checks++;
        if (mem_read !== 1'b0 || i_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL icache_done: got rd %b resp %b expected 0 0", mem_read, i_resp);
        end
        step();
    endtask

    task automatic test_dcache_write();
        d_write = 1'b1;
        d_addr  = 32'h0000_2020;
        d_wdata = {8{32'h1234_5678}};
        step();
        #1;
        n_checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'h0000_2020 || mem_wdata !== {8{32'h1234_5678}}) begin
            n_fail++;
            $display("FAIL dwrite_cmd: got wr %b rd %b addr %h wdata %h", mem_write, mem_read, mem_addr, mem_wdata);
        end
        d_addr  = 32'hDEAD_0000;
        d_wdata = '0;
        step();
        #1;
        n_checks++;
        if (mem_addr !== 32'h0000_2020 || mem_wdata !== {8{32'h1234_5678}} || mem_write !== 1'b1) begin
            n_fail++;
            $display("FAIL dwrite_latched: got addr %h wdata %h wr %b", mem_addr, mem_wdata, mem_write);
        end
        mem_resp = 1'b1;
        #1;
        n_checks++;
        if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL dwrite_resp: got d %b i %b expected 1 0", d_resp, i_resp);
        end
        step();
        mem_resp = 1'b0;
        d_write  = 1'b0;
        #1;
        n_checks++;
        if (d_resp !== 1'b0 || mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL dwrite_done: got resp %b wr %b expected 0 0", d_resp, mem_write);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [LINE_W-1:0] exp_line;
        logic              exp_d;
        i_read = 1'b1;
        i_addr = 32'h0000_3000;
        d_read = 1'b1;
        d_addr = 32'h0000_4000;
        for (int t = 0; t < 4; t++) begin
            exp_d    = (t % 2 == 0);
            exp_line = {8{32'h1000_0000 + t}};
            step();
            #1;
            n_checks++;
            if (mem_read !== 1'b1 || mem_addr !== (exp_d ? 32'h0000_4000 : 32'h0000_3000)) begin
                n_fail++;
                $display("FAIL b2b_grant_t%0d: got rd %b addr %h expected owner d=%b", t, mem_read, mem_addr, exp_d);
            end
            step();
            mem_resp  = 1'b1;
            mem_rdata = exp_line;
            #1;
            n_checks++;
            if (d_resp !== exp_d || i_resp !== !exp_d) begin
                n_fail++;
                $display("FAIL b2b_resp_t%0d: got d %b i %b expected d %b i %b", t, d_resp, i_resp, exp_d, !exp_d);
            end
            n_checks++;
            if (d_rdata !== (exp_d ? exp_line : '0) || i_rdata !== (exp_d ? '0 : exp_line)) begin
                n_fail++;
                $display("FAIL b2b_rdata_t%0d: got d %h i %h", t, d_rdata, i_rdata);
            end
            step();
            mem_resp  = 1'b0;
            mem_rdata = '0;
            #1;
            n_checks++;
            if (mem_read !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_gap1_t%0d: got %b expected 0", t, mem_read);
            end
            step();
            #1;
            n_checks++;
            if (mem_read !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_gap2_t%0d: got %b expected 0", t, mem_read);
            end
        end
        i_read = 1'b0;
        d_read = 1'b0;
        step();
    endtask

    task automatic test_proto_err();
        #1;
        n_checks++;
        if (proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL proto_clear: got %b expected 0", proto_err);
        end
        d_read  = 1'b1;
        d_write = 1'b1;
        d_addr  = 32'h0000_5000;
        d_wdata = {8{32'hCAFE_F00D}};
        step();
        #1;
        n_checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || proto_err !== 1'b1) begin
            n_fail++;
            $display("FAIL proto_write: got wr %b rd %b err %b expected 1 0 1", mem_write, mem_read, proto_err);
        end
        mem_resp = 1'b1;
        step();
        mem_resp = 1'b0;
        d_read   = 1'b0;
        d_write  = 1'b0;
        step();
        i_read = 1'b1;
        i_addr = 32'h0000_6000;
        step();
        mem_resp = 1'b1;
        step();
        mem_resp = 1'b0;
        i_read   = 1'b0;
        step();
        #1;
        n_checks++;
        if (proto_err !== 1'b1) begin
            n_fail++;
            $display("FAIL proto_sticky: got %b expected 1", proto_err);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL proto_reset: got %b expected 0", proto_err);
        end
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_spurious_and_reset();
        mem_resp  = 1'b1;
        mem_rdata = {8{32'hFFFF_FFFF}};
        #1;
        n_checks++;
        if (i_resp !== 1'b0 || d_resp !== 1'b0 || (i_rdata | d_rdata) !== '0) begin
            n_fail++;
            $display("FAIL spurious_idle: got i %b d %b rdata nonzero %b", i_resp, d_resp, |(i_rdata | d_rdata));
        end
        step();
        #1;
        n_checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_no_cmd: got rd %b wr %b expected 0 0", mem_read, mem_write);
        end
        mem_resp = 1'b0;
        d_read   = 1'b1;
        d_addr   = 32'h0000_7000;
        step();
        #1;
        n_checks++;
        if (mem_read !== 1'b1 || mem_addr !== 32'h0000_7000) begin
            n_fail++;
            $display("FAIL midreset_serve: got rd %b addr %h expected 1 00007000", mem_read, mem_addr);
        end
        rst      = 1'b0;
        mem_resp = 1'b1;
        #1;
        n_checks++;
        if (mem_read !== 1'b0 || mem_addr !== '0 || d_resp !== 1'b0 || d_rdata !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got rd %b addr %h resp %b", mem_read, mem_addr, d_resp);
        end
        step();
        #1;
        n_checks++;
        if (d_resp !== 1'b0 || mem_read !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_hold: got resp %b rd %b expected 0 0", d_resp, mem_read);
        end
        clear_inputs();
        rst = 1'b1;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        clear_inputs();
        test_reset();
        test_icache_read();
        test_dcache_write();
        do_reset();
        test_back_to_back();
        do_reset();
        test_proto_err();
        test_spurious_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
